// File: rtl/mem_port_arbiter_pkg.sv
// Shared control types for the unified-memory port arbiter.
// Memory op encoding and arbiter FSM states.
package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    MEM_NOP = 2'd0,
    MEM_LW  = 2'd1,
    MEM_SW  = 2'd2
  } mem_op_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GNT_I = 2'd1,
    GNT_D = 2'd2
  } arb_state_t;

  function automatic logic data_active(
    input logic    req,
    input mem_op_t op
  );
    return req && (op != MEM_NOP);
  endfunction

endpackage

// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter between fetch and load/store.
// Data wins by default; a burst counter bounds fetch starvation.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned MAX_D_BURST = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_valid,
  output logic              if_stall,
  input  logic              d_req,
  input  mem_op_t           d_op,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_valid,
  output logic              d_stall,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ready,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int unsigned CNT_W = $clog2(MAX_D_BURST + 1);
  localparam logic [CNT_W-1:0] BURST_LIM = CNT_W'(MAX_D_BURST);

  arb_state_t        state_q, state_d;
  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
  logic              if_valid_q, if_valid_d;
  logic              d_valid_q, d_valid_d;
  logic [CNT_W-1:0]  burst_cnt_q, burst_cnt_d;

  logic d_act;
  logic fetch_done;
  logic data_done;

  assign d_act      = data_active(d_req, d_op);
  assign fetch_done = (state_q == GNT_I) && mem_ready;
  assign data_done  = (state_q == GNT_D) && mem_ready;

  always_comb begin
    state_d     = state_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if_rdata_d  = if_rdata_q;
    d_rdata_d   = d_rdata_q;
    if_valid_d  = 1'b0;
    d_valid_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (d_act && (!if_req || burst_cnt_q < BURST_LIM)) begin
          state_d     = GNT_D;
          mem_req_d   = 1'b1;
          mem_we_d    = (d_op == MEM_SW);
          mem_addr_d  = d_addr;
          mem_wdata_d = d_wdata;
        end else if (if_req) begin
          state_d    = GNT_I;
          mem_req_d  = 1'b1;
          mem_we_d   = 1'b0;
          mem_addr_d = if_addr;
        end
      end
      GNT_I: begin
        if (mem_ready) begin
          state_d    = IDLE;
          mem_req_d  = 1'b0;
          mem_we_d   = 1'b0;
          if_rdata_d = mem_rdata;
          if_valid_d = if_req;
        end
      end
      GNT_D: begin
        if (mem_ready) begin
          state_d   = IDLE;
          mem_req_d = 1'b0;
          mem_we_d  = 1'b0;
          // stores leave the last load value visible
          if (!mem_we_q) begin
            d_rdata_d = mem_rdata;
          end
          d_valid_d = d_req;
        end
      end
      default: begin
        state_d   = IDLE;
        mem_req_d = 1'b0;
        mem_we_d  = 1'b0;
      end
    endcase
  end

  always_comb begin
    burst_cnt_d = burst_cnt_q;
    if (!if_req || fetch_done) begin
      burst_cnt_d = '0;
    end else if (data_done && burst_cnt_q < BURST_LIM) begin
      burst_cnt_d = burst_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_rdata_q  <= '0;
      d_rdata_q   <= '0;
      if_valid_q  <= 1'b0;
      d_valid_q   <= 1'b0;
      burst_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      if_rdata_q  <= if_rdata_d;
      d_rdata_q   <= d_rdata_d;
      if_valid_q  <= if_valid_d;
      d_valid_q   <= d_valid_d;
      burst_cnt_q <= burst_cnt_d;
    end
  end

  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign if_rdata  = if_rdata_q;
  assign d_rdata   = d_rdata_q;
  assign if_valid  = if_valid_q;
  assign d_valid   = d_valid_q;
  assign if_stall  = if_req && !if_valid_q;
  assign d_stall   = d_act && !d_valid_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed and random bench for mem_port_arbiter.
// Transaction-level model plus a variable-latency memory.
module tb_mem_port_arbiter;
  import mem_port_arbiter_pkg::*;

  localparam int MAXB = 4;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_rdata;
  logic        if_valid;
  logic        if_stall;
  logic        d_req;
  mem_op_t     d_op;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [31:0] d_rdata;
  logic        d_valid;
  logic        d_stall;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ready;
  logic [31:0] mem_rdata;

  mem_port_arbiter #(
    .ADDR_W(32),
    .DATA_W(32),
    .MAX_D_BURST(MAXB)
  ) dut (
    .clk(clk),
    .rst(rst),
    .if_req(if_req),
    .if_addr(if_addr),
    .if_rdata(if_rdata),
    .if_valid(if_valid),
    .if_stall(if_stall),
    .d_req(d_req),
    .d_op(d_op),
    .d_addr(d_addr),
    .d_wdata(d_wdata),
    .d_rdata(d_rdata),
    .d_valid(d_valid),
    .d_stall(d_stall),
    .mem_req(mem_req),
    .mem_we(mem_we),
    .mem_addr(mem_addr),
    .mem_wdata(mem_wdata),
    .mem_ready(mem_ready),
    .mem_rdata(mem_rdata)
  );

  int total = 0;
  int bad = 0;

  bit          m_busy, m_own_d, m_we;
  logic [31:0] m_addr, m_wdata;
  int          lat, wcnt, streak;
  logic        exp_if_valid, exp_d_valid;
  logic [31:0] exp_if_rdata, exp_d_rdata;
  logic [31:0] mem [logic [31:0]];
  bit          gnt_log[$];
  int          force_lat = -1;
  bit          rnd_on = 0;
  bit          i_block, d_block;
  int          d_chain = 0;
  int          cyc = 0;
  int          last_if_cyc, last_d_cyc;
  logic [31:0] last_if_rdata, last_d_rdata;
  int          obs_if_pulses = 0;
  int          obs_d_pulses = 0;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] rd(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return a * 32'h9E37_79B1;
  endfunction

  function automatic logic [31:0] rand_addr();
    return 32'h1000 + 32'($urandom_range(0, 31)) * 32'd4;
  endfunction

  task automatic model_edge();
    bit dact, fd, dd;
    dact = d_req && (d_op != MEM_NOP);
    fd = 0;
    dd = 0;
    if (rst) begin
      m_busy = 0;
      m_we = 0;
      exp_if_valid = 0;
      exp_d_valid = 0;
      exp_if_rdata = 0;
      exp_d_rdata = 0;
      streak = 0;
      return;
    end
    exp_if_valid = 0;
    exp_d_valid = 0;
    if (m_busy) begin
      if (mem_ready) begin
        if (m_own_d) begin
          dd = 1;
          if (m_we) mem[m_addr] = m_wdata;
          else exp_d_rdata = mem_rdata;
          exp_d_valid = d_req;
        end else begin
          fd = 1;
          exp_if_rdata = mem_rdata;
          exp_if_valid = if_req;
        end
        m_busy = 0;
        m_we = 0;
      end
    end else if (dact && (!if_req || streak < MAXB)) begin
      m_busy = 1;
      m_own_d = 1;
      m_we = (d_op == MEM_SW);
      m_addr = d_addr;
      m_wdata = d_wdata;
    end else if (if_req) begin
      m_busy = 1;
      m_own_d = 0;
      m_we = 0;
      m_addr = if_addr;
    end
    if (m_busy && !fd && !dd && wcnt < 0) wcnt = 0;
    if (!if_req || fd) streak = 0;
    else if (dd && streak < MAXB) streak++;
  endtask

  task automatic model_edge_wrap();
    bit was_busy;
    was_busy = m_busy;
    model_edge();
    if (!was_busy && m_busy) begin
      gnt_log.push_back(m_own_d);
      wcnt = 0;
      lat = (force_lat >= 0) ? force_lat : int'($urandom_range(0, 3));
    end
  endtask

  task automatic check_outputs();
    chk("mem_req", 32'(mem_req), 32'(m_busy));
    chk("mem_we", 32'(mem_we), 32'(m_busy && m_we));
    if (m_busy) chk("mem_addr", mem_addr, m_addr);
    if (m_busy && m_own_d && m_we) chk("mem_wdata", mem_wdata, m_wdata);
    chk("if_valid", 32'(if_valid), 32'(exp_if_valid));
    chk("d_valid", 32'(d_valid), 32'(exp_d_valid));
    chk("if_rdata", if_rdata, exp_if_rdata);
    chk("d_rdata", d_rdata, exp_d_rdata);
    if (if_valid === 1'b1) begin
      last_if_cyc = cyc;
      last_if_rdata = if_rdata;
      obs_if_pulses++;
    end
    if (d_valid === 1'b1) begin
      last_d_cyc = cyc;
      last_d_rdata = d_rdata;
      obs_d_pulses++;
    end
  endtask

  task automatic respond();
    mem_ready = 0;
    mem_rdata = $urandom;
    if (m_busy) begin
      if (wcnt == lat) begin
        mem_ready = 1;
        mem_rdata = rd(m_addr);
      end
      wcnt++;
    end
  endtask

  task automatic new_data();
    d_req = 1;
    d_op = ($urandom_range(0, 1) == 1) ? MEM_LW : MEM_SW;
    d_addr = rand_addr();
    d_wdata = $urandom;
  endtask

  task automatic drive_reqs();
    if (if_req && exp_if_valid) begin
      if (rnd_on && $urandom_range(0, 1) == 1) if_addr = rand_addr();
      else if_req = 0;
    end else if (if_req && rnd_on && $urandom_range(0, 15) == 0) begin
      if_req = 0;
      i_block = 1;
    end else if (!if_req && rnd_on) begin
      if (!m_busy) i_block = 0;
      if (!i_block && $urandom_range(0, 2) == 0) begin
        if_req = 1;
        if_addr = rand_addr();
      end
    end
    if (d_req && exp_d_valid) begin
      if (d_chain > 0) begin
        d_chain--;
        d_addr = d_addr + 32'd4;
        d_op = MEM_LW;
      end else if (rnd_on && $urandom_range(0, 1) == 1) begin
        new_data();
      end else begin
        d_req = 0;
        d_op = MEM_NOP;
      end
    end else if (d_req && rnd_on && $urandom_range(0, 15) == 0) begin
      d_req = 0;
      d_op = MEM_NOP;
      d_block = 1;
    end else if (!d_req && rnd_on) begin
      if (!m_busy) d_block = 0;
      if (!d_block && $urandom_range(0, 2) == 0) new_data();
    end
  endtask

  task automatic step();
    #1;
    chk("if_stall", 32'(if_stall), 32'(if_req && !exp_if_valid));
    chk("d_stall", 32'(d_stall),
        32'(d_req && d_op != MEM_NOP && !exp_d_valid));
    model_edge_wrap();
    @(posedge clk);
    #1;
    cyc++;
    check_outputs();
    respond();
    drive_reqs();
  endtask

  task automatic run(input int max);
    bit quiet;
    quiet = 0;
    for (int n = 0; n < max; n++) begin
      step();
      if (!m_busy && !if_req && !d_req) begin
        quiet = 1;
        break;
      end
    end
    chk("run_timeout", 32'(quiet), 32'd1);
  endtask

  int c0, base;

  initial begin
    rst = 1;
    if_req = 0;
    if_addr = 0;
    d_req = 0;
    d_op = MEM_NOP;
    d_addr = 0;
    d_wdata = 0;
    mem_ready = 0;
    mem_rdata = 0;
    m_busy = 0;
    m_own_d = 0;
    m_we = 0;
    m_addr = 0;
    m_wdata = 0;
    lat = 0;
    wcnt = 0;
    streak = 0;
    exp_if_valid = 0;
    exp_d_valid = 0;
    exp_if_rdata = 0;
    exp_d_rdata = 0;
    i_block = 0;
    d_block = 0;
    repeat (2) @(posedge clk);
    #1;

    // reset state
    step();
    step();
    chk("rst_mem_addr", mem_addr, 32'h0);
    chk("rst_mem_wdata", mem_wdata, 32'h0);
    rst = 0;

    // fetch only, memory answers 3 cycles after mem_req
    mem[32'h100] = 32'h0050_0093;
    force_lat = 3;
    c0 = cyc;
    if_req = 1;
    if_addr = 32'h100;
    step();
    chk("fetch_addr", mem_addr, 32'h100);
    run(20);
    chk("fetch_lat", 32'(last_if_cyc - c0), 32'd5);
    chk("fetch_data", last_if_rdata, 32'h0050_0093);

    // load and fetch collide: data first, fetch after one idle cycle
    mem[32'h200] = 32'hDEAD_BEEF;
    force_lat = 0;
    base = gnt_log.size();
    c0 = cyc;
    if_req = 1;
    if_addr = 32'h104;
    d_req = 1;
    d_op = MEM_LW;
    d_addr = 32'h200;
    run(20);
    chk("coll_first_d", 32'(gnt_log[base]), 32'd1);
    chk("coll_then_i", 32'(gnt_log[base+1]), 32'd0);
    chk("coll_ld_data", last_d_rdata, 32'hDEAD_BEEF);
    chk("coll_d_lat", 32'(last_d_cyc - c0), 32'd2);
    chk("coll_i_lat", 32'(last_if_cyc - c0), 32'd4);

    // store leaves d_rdata alone
    force_lat = 2;
    c0 = cyc;
    d_req = 1;
    d_op = MEM_SW;
    d_addr = 32'h204;
    d_wdata = 32'h1234_5678;
    step();
    chk("st_we", 32'(mem_we), 32'd1);
    chk("st_wdata", mem_wdata, 32'h1234_5678);
    run(20);
    chk("st_lat", 32'(last_d_cyc - c0), 32'd4);
    chk("st_rdata_kept", d_rdata, 32'hDEAD_BEEF);

    // op NOP with d_req high is not a request
    d_req = 1;
    d_op = MEM_NOP;
    repeat (3) step();
    chk("nop_no_req", 32'(mem_req), 32'd0);
    d_req = 0;

    // starvation guard: 4 data grants, fetch, then 5th load
    force_lat = 1;
    base = gnt_log.size();
    if_req = 1;
    if_addr = 32'h108;
    d_req = 1;
    d_op = MEM_LW;
    d_addr = 32'h300;
    d_chain = 4;
    run(100);
    chk("starve_cnt", 32'(gnt_log.size() - base), 32'd6);
    for (int k = 0; k < 6; k++) begin
      chk("starve_order", 32'(gnt_log[base+k]), (k == 4) ? 32'd0 : 32'd1);
    end

    // fetch flushed while granted: no pulse, then pending load
    force_lat = 3;
    base = gnt_log.size();
    c0 = obs_if_pulses;
    if_req = 1;
    if_addr = 32'h10C;
    step();
    step();
    if_req = 0;
    d_req = 1;
    d_op = MEM_LW;
    d_addr = 32'h200;
    run(40);
    chk("flush_no_pulse", 32'(obs_if_pulses - c0), 32'd0);
    chk("flush_first_i", 32'(gnt_log[base]), 32'd0);
    chk("flush_then_d", 32'(gnt_log[base+1]), 32'd1);
    chk("flush_ld_data", last_d_rdata, 32'hDEAD_BEEF);

    // reset in the middle of a store
    force_lat = 6;
    d_req = 1;
    d_op = MEM_SW;
    d_addr = 32'h208;
    d_wdata = 32'hCAFE_F00D;
    step();
    step();
    chk("mid_busy", 32'(mem_req), 32'd1);
    rst = 1;
    d_req = 0;
    d_op = MEM_NOP;
    step();
    chk("rst_req", 32'(mem_req), 32'd0);
    chk("rst_we", 32'(mem_we), 32'd0);
    chk("rst_dval", 32'(d_valid), 32'd0);
    chk("rst_ival", 32'(if_valid), 32'd0);
    chk("rst_addr", mem_addr, 32'h0);
    chk("rst_drd", d_rdata, 32'h0);
    rst = 0;
    force_lat = 1;
    if_req = 1;
    if_addr = 32'h100;
    run(20);
    chk("post_rst_fetch", last_if_rdata, 32'h0050_0093);

    // random traffic against the model
    force_lat = -1;
    rnd_on = 1;
    repeat (4000) step();
    rnd_on = 0;
    run(300);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
